nand_test_sequencer: RTL and testbench

NAND_TEST_SEQUENCER -- requirements
Module: nand_test_sequencer

---
 rtl/nand_test_sequencer_if.sv | 24 ++
 rtl/nand_test_sequencer.sv | 129 ++++++++++++
 tb/tb_nand_test_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/nand_test_sequencer_if.sv
// Control handshake and gate-under-test bus of the NAND test sequencer.
// The sequencer uses the master modport; the harness/gate side uses slave.
interface nand_test_sequencer_if;
    logic       start;
    logic       abort;
    logic       dut_y;
    logic       dut_a;
    logic       dut_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [3:0] fail_vec;

    modport master (
        input  start, abort, dut_y,
        output dut_a, dut_b, busy, done, pass, err_cnt, fail_vec
    );

    modport slave (
        output start, abort, dut_y,
        input  dut_a, dut_b, busy, done, pass, err_cnt, fail_vec
    );
endinterface

// File: rtl/nand_test_sequencer.sv
// Exhaustive 2-input gate tester: applies {a,b} = 00,01,10,11, waits
// SETTLE_CYCLES after each vector, samples dut_y once and compares it with
// EXP_TT[{a,b}]. Reports a mismatch count, per-vector fail flags and pass.
module nand_test_sequencer #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] EXP_TT        = 4'b0111
) (
    input logic                    clk,
    input logic                    rst_n,
    nand_test_sequencer_if.master  bus
);

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_nx;
    logic [1:0] idx, idx_nx;
    logic [3:0] cnt, cnt_nx;

    logic in_run;
    logic in_run_nx;
    logic accept;
    logic check_en;
    logic mismatch;

    assign in_run    = (state == APPLY) || (state == SETTLE) || (state == CHECK);
    assign in_run_nx = (state_nx == APPLY) || (state_nx == SETTLE) || (state_nx == CHECK);
    // abort in IDLE suppresses a same-cycle start
    assign accept    = (state == IDLE) && bus.start && !bus.abort;
    // abort wins over a CHECK result landing in the same cycle
    assign check_en  = (state == CHECK) && !bus.abort;
    // case inequality so an undriven or X gate output reads as a failure
    assign mismatch  = (bus.dut_y !== EXP_TT[idx]);

    // Sequencing registers: state, vector index and settle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= 2'd0;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state: APPLY(1) -> SETTLE(SETTLE_CYCLES) -> CHECK(1) per vector
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        if (in_run && bus.abort) begin
            state_nx = IDLE;
            idx_nx   = 2'd0;
            cnt_nx   = 4'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state_nx = APPLY;
                    idx_nx   = 2'd0;
                end
                APPLY: begin
                    state_nx = SETTLE;
                    cnt_nx   = SETTLE_LOAD;
                end
                SETTLE: begin
                    if (cnt == 4'd0) state_nx = CHECK;
                    else             cnt_nx   = cnt - 4'd1;
                end
                CHECK: begin
                    if (idx == 2'd3) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = APPLY;
                        idx_nx   = idx + 2'd1;
                    end
                end
                DONE: begin
                    state_nx = IDLE;
                    idx_nx   = 2'd0;
                end
                default: begin
                    state_nx = IDLE;
                    idx_nx   = 2'd0;
                    cnt_nx   = 4'd0;
                end
            endcase
        end
    end

    // Status outputs decoded straight from the state register
    always_comb begin
        bus.busy = in_run;
        bus.done = (state == DONE);
    end

    // Result bookkeeping and registered gate inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dut_a    <= 1'b0;
            bus.dut_b    <= 1'b0;
            bus.pass     <= 1'b0;
            bus.err_cnt  <= 3'd0;
            bus.fail_vec <= 4'd0;
        end else begin
            // vector stays on the gate from APPLY through its CHECK, else 00
            bus.dut_a <= in_run_nx ? idx_nx[1] : 1'b0;
            bus.dut_b <= in_run_nx ? idx_nx[0] : 1'b0;
            if (accept) begin
                bus.pass     <= 1'b0;
                bus.err_cnt  <= 3'd0;
                bus.fail_vec <= 4'd0;
            end else if (check_en) begin
                if (mismatch) begin
                    bus.err_cnt       <= bus.err_cnt + 3'd1;
                    bus.fail_vec[idx] <= 1'b1;
                end
                // pass must include the result of the last vector
                if (idx == 2'd3)
                    bus.pass <= (bus.err_cnt == 3'd0) && !mismatch;
            end else if (in_run && bus.abort) begin
                bus.pass <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nand_test_sequencer.sv
// Directed bench for nand_test_sequencer: two instances, SETTLE_CYCLES=2
// and SETTLE_CYCLES=15, each driving a behavioural gate model.
module tb_nand_test_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] mode;    // DUT1 gate: 0 NAND, 1 stuck-at-1, 2 AND
    logic glitch;        // DUT2 gate: inverts NAND output while set

    int n_cmp = 0;
    int n_bad = 0;

    nand_test_sequencer_if bus1();
    nand_test_sequencer_if bus2();

    nand_test_sequencer #(.SETTLE_CYCLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    nand_test_sequencer #(.SETTLE_CYCLES(15)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    assign bus1.dut_y = (mode == 2'd1) ? 1'b1 :
                        (mode == 2'd2) ? (bus1.dut_a & bus1.dut_b) :
                                         ~(bus1.dut_a & bus1.dut_b);
    assign bus2.dut_y = ~(bus2.dut_a & bus2.dut_b) ^ glitch;

    always #5 clk = ~clk;

    // One DUT1 run: start pulse before cycle 1, optional re-start / abort in
    // given busy cycles; records busy count, done cycle and the vectors seen
    // in cycles 1,5,9,13.
    task automatic run1(input int restart_cyc, input int abort_cyc,
                        output int done_cyc, output int busy_cyc,
                        output logic [7:0] seq);
        done_cyc = -1;
        busy_cyc = 0;
        seq      = 8'h00;
        @(negedge clk);
        bus1.start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (bus1.busy) busy_cyc++;
            if (bus1.done && done_cyc < 0) done_cyc = c;
            if (c <= 13 && ((c - 1) % 4) == 0)
                seq[7 - 2*((c - 1) / 4) -: 2] = {bus1.dut_a, bus1.dut_b};
            bus1.start = (c == restart_cyc);
            bus1.abort = (c == abort_cyc);
        end
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        n_cmp++; if (bus1.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus1.busy); end
        n_cmp++; if (bus1.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus1.done); end
        n_cmp++; if ({bus1.dut_a, bus1.dut_b} !== 2'b00) begin n_bad++; $display("FAIL reset_ab: got %b%b want 00", bus1.dut_a, bus1.dut_b); end
        n_cmp++; if ({bus1.pass, bus1.err_cnt, bus1.fail_vec} !== 8'h00) begin n_bad++; $display("FAIL reset_results: got pass=%b err=%0d fail=%b want 0", bus1.pass, bus1.err_cnt, bus1.fail_vec); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nand_pass;
        int d, b; logic [7:0] s;
        mode = 2'd0;
        run1(0, 0, d, b, s);
        n_cmp++; if (s !== 8'h1B) begin n_bad++; $display("FAIL nand_seq: got %h want 1b", s); end
        n_cmp++; if (b !== 16) begin n_bad++; $display("FAIL nand_busy_cycles: got %0d want 16", b); end
        n_cmp++; if (d !== 17) begin n_bad++; $display("FAIL nand_done_cycle: got %0d want 17", d); end
        n_cmp++; if (bus1.pass !== 1'b1) begin n_bad++; $display("FAIL nand_pass: got %b want 1", bus1.pass); end
        n_cmp++; if (bus1.err_cnt !== 3'd0) begin n_bad++; $display("FAIL nand_err: got %0d want 0", bus1.err_cnt); end
        n_cmp++; if (bus1.fail_vec !== 4'b0000) begin n_bad++; $display("FAIL nand_failvec: got %b want 0000", bus1.fail_vec); end
    endtask

    task automatic test_stuck1;
        int d, b; logic [7:0] s;
        mode = 2'd1;
        run1(0, 0, d, b, s);
        n_cmp++; if (d !== 17) begin n_bad++; $display("FAIL stuck_done_cycle: got %0d want 17", d); end
        n_cmp++; if (bus1.pass !== 1'b0) begin n_bad++; $display("FAIL stuck_pass: got %b want 0", bus1.pass); end
        n_cmp++; if (bus1.err_cnt !== 3'd1) begin n_bad++; $display("FAIL stuck_err: got %0d want 1", bus1.err_cnt); end
        n_cmp++; if (bus1.fail_vec !== 4'b1000) begin n_bad++; $display("FAIL stuck_failvec: got %b want 1000", bus1.fail_vec); end
    endtask

    task automatic test_and_gate;
        int d, b; logic [7:0] s;
        mode = 2'd2;
        run1(0, 0, d, b, s);
        n_cmp++; if (bus1.err_cnt !== 3'd4) begin n_bad++; $display("FAIL and_err: got %0d want 4", bus1.err_cnt); end
        n_cmp++; if (bus1.fail_vec !== 4'b1111) begin n_bad++; $display("FAIL and_failvec: got %b want 1111", bus1.fail_vec); end
        n_cmp++; if (bus1.pass !== 1'b0) begin n_bad++; $display("FAIL and_pass: got %b want 0", bus1.pass); end
    endtask

    // start+abort together in IDLE must not start; results stay held
    task automatic test_idle_abort;
        @(negedge clk);
        bus1.start = 1'b1;
        bus1.abort = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
        n_cmp++; if (bus1.busy !== 1'b0) begin n_bad++; $display("FAIL idle_abort_busy: got %b want 0", bus1.busy); end
        n_cmp++; if (bus1.err_cnt !== 3'd4) begin n_bad++; $display("FAIL idle_abort_hold: got %0d want 4", bus1.err_cnt); end
    endtask

    // AND gate mismatches vectors 0 and 1, abort lands in idx=2 SETTLE
    task automatic test_abort_settle;
        int d, b; logic [7:0] s;
        mode = 2'd2;
        run1(5, 10, d, b, s);
        n_cmp++; if (s !== 8'h18) begin n_bad++; $display("FAIL abort_seq: got %h want 18", s); end
        n_cmp++; if (b !== 10) begin n_bad++; $display("FAIL abort_busy_cycles: got %0d want 10", b); end
        n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL abort_no_done: got %0d want -1", d); end
        n_cmp++; if ({bus1.dut_a, bus1.dut_b} !== 2'b00) begin n_bad++; $display("FAIL abort_ab: got %b%b want 00", bus1.dut_a, bus1.dut_b); end
        n_cmp++; if (bus1.fail_vec !== 4'b0011) begin n_bad++; $display("FAIL abort_failvec: got %b want 0011", bus1.fail_vec); end
        n_cmp++; if (bus1.err_cnt !== 3'd2) begin n_bad++; $display("FAIL abort_err: got %0d want 2", bus1.err_cnt); end
        n_cmp++; if (bus1.pass !== 1'b0) begin n_bad++; $display("FAIL abort_pass: got %b want 0", bus1.pass); end
    endtask

    // abort in idx=0 CHECK, where the AND gate mismatches: no update
    task automatic test_abort_check;
        int d, b; logic [7:0] s;
        mode = 2'd2;
        run1(0, 4, d, b, s);
        n_cmp++; if (b !== 4) begin n_bad++; $display("FAIL abortchk_busy_cycles: got %0d want 4", b); end
        n_cmp++; if (bus1.err_cnt !== 3'd0) begin n_bad++; $display("FAIL abortchk_err: got %0d want 0", bus1.err_cnt); end
        n_cmp++; if (bus1.fail_vec !== 4'b0000) begin n_bad++; $display("FAIL abortchk_failvec: got %b want 0000", bus1.fail_vec); end
    endtask

    task automatic test_reset_mid;
        int d, b; logic [7:0] s;
        mode = 2'd2;
        @(negedge clk);
        bus1.start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus1.start = 1'b0;
        end
        n_cmp++; if (bus1.err_cnt !== 3'd1) begin n_bad++; $display("FAIL midrst_pre_err: got %0d want 1", bus1.err_cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus1.busy, bus1.done, bus1.dut_a, bus1.dut_b} !== 4'b0000) begin n_bad++; $display("FAIL midrst_ctl: got %b want 0000", {bus1.busy, bus1.done, bus1.dut_a, bus1.dut_b}); end
        n_cmp++; if ({bus1.pass, bus1.err_cnt, bus1.fail_vec} !== 8'h00) begin n_bad++; $display("FAIL midrst_results: got %h want 00", {bus1.pass, bus1.err_cnt, bus1.fail_vec}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus1.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_idle: got %b want 0", bus1.busy); end
        mode = 2'd0;
        run1(0, 0, d, b, s);
        n_cmp++; if (d !== 17) begin n_bad++; $display("FAIL midrst_done_cycle: got %0d want 17", d); end
        n_cmp++; if (bus1.pass !== 1'b1) begin n_bad++; $display("FAIL midrst_pass: got %b want 1", bus1.pass); end
    endtask

    // 17 cycles per vector: APPLY, 15 SETTLE, CHECK; glitch only in SETTLE
    task automatic test_settle15;
        int d = -1;
        int b = 0;
        int p;
        @(negedge clk);
        bus2.start = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            bus2.start = 1'b0;
            if (bus2.busy) b++;
            if (bus2.done && d < 0) d = c;
            p = (c - 1) % 17;
            glitch = (c <= 68) && (p >= 1) && (p <= 15);
        end
        glitch = 1'b0;
        n_cmp++; if (d !== 69) begin n_bad++; $display("FAIL s15_done_cycle: got %0d want 69", d); end
        n_cmp++; if (b !== 68) begin n_bad++; $display("FAIL s15_busy_cycles: got %0d want 68", b); end
        n_cmp++; if (bus2.pass !== 1'b1) begin n_bad++; $display("FAIL s15_pass: got %b want 1", bus2.pass); end
        n_cmp++; if (bus2.err_cnt !== 3'd0) begin n_bad++; $display("FAIL s15_err: got %0d want 0", bus2.err_cnt); end
    endtask

    initial begin
        rst_n      = 1'b0;
        mode       = 2'd0;
        glitch     = 1'b0;
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
        bus2.start = 1'b0;
        bus2.abort = 1'b0;
        test_reset();
        test_nand_pass();
        test_stuck1();
        test_and_gate();
        test_idle_abort();
        test_abort_settle();
        test_abort_check();
        test_reset_mid();
        test_settle15();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
